nzcv_cond_unit: RTL

NZCV_COND_UNIT -- requirements
Module: nzcv_cond_unit

---
 rtl/nzcv_cond_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/nzcv_cond_unit.sv
// NZCV flag register with an ARM-style condition evaluator behind a
// one-deep valid/ready output stage and a saturating pass counter.
module nzcv_cond_unit #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flags_we,
  input  logic [3:0]       i_nzcv,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_cond,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_pass,
  output logic [TAG_W-1:0] o_tag,
  output logic [3:0]       o_nzcv,
  output logic [7:0]       o_pass_cnt
);

  logic [3:0]       flags_q;
  logic             valid_q;
  logic             pass_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       cnt_q;

  logic accept;
  logic deliver;
  logic cond_true;
  logic n, z, c, v;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  // Output slot is free when empty or being drained this cycle.
  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;
  assign deliver = valid_q & i_ready;

  // Condition decode against the flags currently held (pre-edge value).
  always_comb begin
    cond_true = 1'b0;
    case (i_cond)
      4'h0:    cond_true = z;
      4'h1:    cond_true = ~z;
      4'h2:    cond_true = c;
      4'h3:    cond_true = ~c;
      4'h4:    cond_true = n;
      4'h5:    cond_true = ~n;
      4'h6:    cond_true = v;
      4'h7:    cond_true = ~v;
      4'h8:    cond_true = c & ~z;
      4'h9:    cond_true = ~c | z;
      4'hA:    cond_true = (n == v);
      4'hB:    cond_true = (n != v);
      4'hC:    cond_true = ~z & (n == v);
      4'hD:    cond_true = z | (n != v);
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Flag register; writes are independent of the handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flags_q <= 4'b0000;
    end else if (i_flags_we) begin
      flags_q <= i_nzcv;
    end
  end

  // Output register: load on accept, drop on delivery without refill.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      tag_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pass_q  <= cond_true;
      tag_q   <= i_tag;
    end else if (deliver) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating count of delivered passing results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= 8'd0;
    end else if (deliver && pass_q && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign o_valid    = valid_q;
  assign o_pass     = pass_q;
  assign o_tag      = tag_q;
  assign o_nzcv     = flags_q;
  assign o_pass_cnt = cnt_q;

endmodule
